// File: rtl/sweep_controller_if.sv
// Strobe/status bundle between sweep_controller and the one-hot shift datapath.
// The pause line is present only when CTRL_PAUSE_EN is defined.
interface sweep_controller_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             stop;
`ifdef CTRL_PAUSE_EN
    logic             pause;
`endif
    logic [WIDTH-1:0] count;
    logic             dp_done;
    logic             load;
    logic             shift_left;
    logic             shift_right;
    logic             busy;
    logic             finished;
    logic [7:0]       pass_cnt;

    // Controller side: drives the strobes and status.
    modport master (
`ifdef CTRL_PAUSE_EN
        input  pause,
`endif
        input  start, stop, count, dp_done,
        output load, shift_left, shift_right, busy, finished, pass_cnt
    );

    // Environment side: datapath plus whoever issues start/stop.
    modport slave (
`ifdef CTRL_PAUSE_EN
        output pause,
`endif
        output start, stop, count, dp_done,
        input  load, shift_left, shift_right, busy, finished, pass_cnt
    );
endinterface

// File: rtl/sweep_controller.sv
// Sweeps a one-hot datapath LSB->MSB->LSB at one strobe per TICK_DIV cycles.
// Optional feature macro: CTRL_PAUSE_EN (adds pause, which freezes stepping).
module sweep_controller #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned PASSES   = 2
) (
    input  logic               clk,
    input  logic               reset,
    sweep_controller_if.master bus
);
    localparam int unsigned       TICK_W      = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
    localparam logic [7:0]        PASS_TARGET = 8'(PASSES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LEFT,
        ST_RIGHT,
        ST_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [7:0]        pass_q, pass_d;
    logic              load_q, load_d;
    logic              shl_q, shl_d;
    logic              shr_q, shr_d;
    logic              fin_q, fin_d;
    logic              busy_q;
    logic              paused;
    logic              tick_end;
    logic [7:0]        pass_inc;

`ifdef CTRL_PAUSE_EN
    assign paused = bus.pause;
`else
    assign paused = 1'b0;
`endif

    // The tick counter holds cycles elapsed since the last strobe (load included).
    assign tick_end = (tick_q == TICK_LAST);
    assign pass_inc = pass_q + 8'd1;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        pass_d  = pass_q;
        load_d  = 1'b0;
        shl_d   = 1'b0;
        shr_d   = 1'b0;
        fin_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_LOAD;
                    load_d  = 1'b1;
                    tick_d  = '0;
                    pass_d  = '0;
                end
            end
            ST_LOAD: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LEFT;
                    tick_d  = tick_q + TICK_W'(1);
                end
            end
            ST_LEFT, ST_RIGHT: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (!paused) begin
                    tick_d = tick_end ? '0 : tick_q + TICK_W'(1);
                    // A datapath wrap means count is back at the LSB: resume climbing.
                    if (bus.dp_done) begin
                        state_d = ST_LEFT;
                    end else if (tick_end) begin
                        if (state_q == ST_LEFT) begin
                            if (bus.count[WIDTH-1]) begin
                                shr_d   = 1'b1;
                                state_d = ST_RIGHT;
                            end else begin
                                shl_d = 1'b1;
                            end
                        end else if (!bus.count[0]) begin
                            shr_d = 1'b1;
                        end else begin
                            pass_d = pass_inc;
                            if (PASSES != 0 && pass_inc == PASS_TARGET) begin
                                state_d = ST_FINISH;
                                fin_d   = 1'b1;
                            end else begin
                                shl_d   = 1'b1;
                                state_d = ST_LEFT;
                            end
                        end
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            pass_q  <= '0;
            load_q  <= 1'b0;
            shl_q   <= 1'b0;
            shr_q   <= 1'b0;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            pass_q  <= pass_d;
            load_q  <= load_d;
            shl_q   <= shl_d;
            shr_q   <= shr_d;
            fin_q   <= fin_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign bus.load        = load_q;
    assign bus.shift_left  = shl_q;
    assign bus.shift_right = shr_q;
    assign bus.finished    = fin_q;
    assign bus.busy        = busy_q;
    assign bus.pass_cnt    = pass_q;
endmodule

// File: doc/sweep_controller.md
# sweep_controller

Control FSM that sits directly upstream of the one-hot shift datapath. It issues single-cycle `load`, `shift_left` and `shift_right` strobes so the lit bit sweeps from LSB to MSB and back, at a programmable step rate. It monitors the datapath's `count` and `done` outputs to decide direction and to resynchronise. It counts completed sweeps and stops after a programmable number of them.

## Interface
- `WIDTH`, 8: width of the datapath `count` bus.
- `TICK_DIV`, 4: clock cycles between consecutive strobes; legal range is 2 or more.
- `PASSES`, 2: number of full sweeps before finishing; 0 means run until `stop`.

- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  level; sampled only in IDLE.
- `stop`  in  1  level; aborts any active state.
- `pause`  in  1  freezes stepping; present only with `CTRL_PAUSE_EN`.
- `count`  in  WIDTH  current one-hot value from the datapath.
- `dp_done`  in  1  datapath wrap indication.
- `load`  out  1  one-cycle strobe; datapath loads its `data_in`.
- `shift_left`  out  1  one-cycle strobe.
- `shift_right`  out  1  one-cycle strobe.
- `busy`  out  1  high whenever the state is not IDLE.
- `finished`  out  1  one-cycle pulse when the sweep target is reached.
- `pass_cnt`  out  8  completed sweeps since the last LOAD.

## Operation
- States: IDLE, LOAD, LEFT, RIGHT, FINISH. All outputs are registered.
- IDLE
  - All strobes low.
  - `start`=1 moves to LOAD.
- LOAD
  - `load`=1 for exactly one cycle.
  - `pass_cnt` and the tick counter clear.
  - Next state is LEFT.
- LEFT and RIGHT
  - The tick counter runs 0..TICK_DIV-1.
  - At the terminal tick the FSM makes exactly one decision, using `count` sampled on that edge.
- LEFT decision
  - If `count[WIDTH-1]`=1: issue `shift_right` and go to RIGHT.
  - Otherwise: issue `shift_left`.
- RIGHT decision
  - If `count[0]`=0: issue `shift_right`.
  - If `count[0]`=1, a sweep is complete and `pass_cnt` increments (wraps 255 to 0).
  - If `PASSES`≠0 and the new `pass_cnt` equals `PASSES`: go to FINISH and issue no strobe.
  - Otherwise: issue `shift_left` and go to LEFT.
- FINISH: `finished`=1 for one cycle, then IDLE. `pass_cnt` holds its value until the next LOAD.
- `dp_done`=1 sampled in LEFT or RIGHT
  - The datapath count has returned to 0x01, so the state is forced to LEFT.
  - The tick counter is not disturbed and `pass_cnt` is unchanged.
- Priority, highest first:
  1. `reset`
  2. `stop`
  3. `pause`
  4. `dp_done`
  5. tick decision
- `stop` in any non-IDLE state: next state is IDLE, and no strobe is issued on that edge.
- `start` while `busy`=1 is ignored.
- Exactly one strobe may be high in any cycle; `load` never coincides with a shift strobe.

## Timing
- Reset values: state IDLE, and every output 0 (`load`, `shift_left`, `shift_right`, `busy`, `finished`, `pass_cnt`). Reset takes effect immediately, mid-operation included.
- Start to load: when `start` is sampled high at edge k, `load` is high in the cycle after edge k, and `busy` rises in the same cycle.
- First strobe: `shift_left` is high exactly TICK_DIV cycles after the `load` cycle.
- Strobe spacing: exactly TICK_DIV cycles between strobes, including across direction changes.
- Stop latency: `busy` falls one cycle after `stop` is sampled.
- Datapath settling: the datapath updates `count` on the edge that samples a strobe. `TICK_DIV`≥2 guarantees the next decision sees the updated value.
- Sweep length: from `count`=0x01 with WIDTH=8, a sweep is 7 `shift_left` plus 7 `shift_right`, i.e. 14 strobes, or 56 cycles at TICK_DIV=4.

## Configuration
- `CTRL_PAUSE_EN` defined
  - The `pause` port exists.
  - While `pause`=1 in LEFT or RIGHT, the tick counter freezes and no strobe is issued.
  - Stepping resumes from the frozen tick value when `pause` falls.
  - `stop` and `reset` still act during pause.
- `CTRL_PAUSE_EN` undefined: there is no `pause` port and stepping is never frozen.

## Test plan
- Reset: assert `reset` mid-RIGHT → all outputs 0 and `busy`=0 immediately; after release the block stays IDLE until `start`.
- Single sweep (PASSES=1, TICK_DIV=4, datapath model with data_in 0x01), pulse `start`:
  - one `load`;
  - 7 `shift_left` bringing `count` to 0x80;
  - 7 `shift_right` returning it to 0x01, strobes 4 cycles apart;
  - then `finished` pulses and `pass_cnt`=1.
- Stop: assert `stop` after the 3rd `shift_left` (`count`=0x08) → no further strobes, `busy`=0 next cycle, `count` holds 0x08.
- Start while busy: pulse `start` during LEFT → no second `load`, and strobe spacing is unchanged.
- Run-forever wrap (PASSES=0), against a datapath that wraps after 18 strobes:
  - the 18th strobe yields `count`=0x01 and `dp_done`;
  - the next strobe is `shift_left`, and `pass_cnt`=1 at that point.
- Pause (`CTRL_PAUSE_EN`): hold `pause` for 10 cycles mid-LEFT → no strobes during the hold; the next strobe comes the remaining ticks after `pause` falls.
